// File: rtl/alu_arbiter.sv
// Round-robin arbiter sharing one combinational ALU between two requesters.
// Optional divide-by-zero trap enabled by defining ALU_ARB_DIV0_TRAP_EN.
module alu_arbiter #(
    parameter int MULDIV_CYCLES = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req0,
    input  logic        req1,
    input  logic [3:0]  op0,
    input  logic [3:0]  op1,
    input  logic [31:0] a0,
    input  logic [31:0] a1,
    input  logic [31:0] b0,
    input  logic [31:0] b1,
    input  logic [4:0]  sh0,
    input  logic [4:0]  sh1,
    output logic        gnt0,
    output logic        gnt1,
    output logic [3:0]  alu_sel,
    output logic [31:0] alu_in1,
    output logic [31:0] alu_in2,
    output logic [4:0]  alu_sra,
    input  logic [31:0] alu_out,
    input  logic [5:0]  alu_flags,
    output logic        rvalid,
    output logic        rid,
    output logic [31:0] result,
    output logic [5:0]  rflags,
    output logic        err,
    output logic        busy
);

    localparam int CW = (MULDIV_CYCLES > 1) ? $clog2(MULDIV_CYCLES) : 1;
    localparam logic [CW-1:0] MD_LOAD = CW'(MULDIV_CYCLES - 1);

    typedef enum logic {IDLE, EXEC} state_t;

    state_t        state;
    logic          last;
    logic          cur_id;
    logic          cur_trap;
    logic [CW-1:0] cnt;

    logic          idle;
    logic          win;
    logic [3:0]    win_op;
    logic [31:0]   win_a;
    logic [31:0]   win_b;
    logic [4:0]    win_sh;
    logic          win_muldiv;
    logic          win_trap;

    // On a tie the requester that did not win last time gets the ALU
    assign idle = (state == IDLE);
    assign gnt0 = rst_n && idle && req0 && (!req1 || last);
    assign gnt1 = rst_n && idle && req1 && (!req0 || !last);
    assign busy = (state == EXEC);

    assign win        = gnt1;
    assign win_op     = win ? op1 : op0;
    assign win_a      = win ? a1  : a0;
    assign win_b      = win ? b1  : b0;
    assign win_sh     = win ? sh1 : sh0;
    assign win_muldiv = (win_op == 4'b0010) || (win_op == 4'b0011) || (win_op == 4'b0100);

`ifdef ALU_ARB_DIV0_TRAP_EN
    assign win_trap = ((win_op == 4'b0011) || (win_op == 4'b0100)) && (win_b == 32'd0);
`else
    assign win_trap = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state    <= IDLE;
            last     <= 1'b1;
            cur_id   <= 1'b0;
            cur_trap <= 1'b0;
            cnt      <= '0;
            alu_sel  <= '0;
            alu_in1  <= '0;
            alu_in2  <= '0;
            alu_sra  <= '0;
            rvalid   <= 1'b0;
            rid      <= 1'b0;
            result   <= '0;
            rflags   <= '0;
            err      <= 1'b0;
        end else begin
            rvalid <= 1'b0;
            case (state)
                IDLE: begin
                    if (gnt0 || gnt1) begin
                        state    <= EXEC;
                        last     <= win;
                        cur_id   <= win;
                        cur_trap <= win_trap;
                        cnt      <= (win_muldiv && !win_trap) ? MD_LOAD : '0;
                        // A trapped divide never reaches the ALU
                        if (!win_trap) begin
                            alu_sel <= win_op;
                            alu_in1 <= win_a;
                            alu_in2 <= win_b;
                            alu_sra <= win_sh;
                        end
                    end
                end
                EXEC: begin
                    if (cnt != '0) begin
                        cnt <= cnt - 1'b1;
                    end else begin
                        state  <= IDLE;
                        rvalid <= 1'b1;
                        rid    <= cur_id;
                        result <= cur_trap ? 32'd0 : alu_out;
                        rflags <= cur_trap ? 6'b100000 : alu_flags;
                        err    <= cur_trap;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_alu_arbiter.sv
// Bench for alu_arbiter: directed scenarios followed by random traffic, all
// checked against a transaction-level model with a stand-in ALU.
module tb_alu_arbiter;

    localparam int MD = 4;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        req0, req1;
    logic [3:0]  op0, op1;
    logic [31:0] a0, a1, b0, b1;
    logic [4:0]  sh0, sh1;
    logic        gnt0, gnt1;
    logic [3:0]  alu_sel;
    logic [31:0] alu_in1, alu_in2;
    logic [4:0]  alu_sra;
    logic [31:0] alu_out;
    logic [5:0]  alu_flags;
    logic        rvalid, rid, err, busy;
    logic [31:0] result;
    logic [5:0]  rflags;

    int checks = 0;
    int failures = 0;

    // Model state: remaining execution cycles, round-robin memory, and the
    // expected contents of every registered output
    int          m_left;
    bit          m_last;
    bit          m_id;
    bit          m_trap;
    logic [3:0]  e_sel;
    logic [31:0] e_in1, e_in2, e_result;
    logic [4:0]  e_sra;
    logic        e_rvalid, e_rid, e_err;
    logic [5:0]  e_rflags;
    int          xfer_id;
    int          obs_win;

    alu_arbiter #(.MULDIV_CYCLES(MD)) dut (
        .clk(clk), .rst_n(rst_n),
        .req0(req0), .req1(req1), .op0(op0), .op1(op1),
        .a0(a0), .a1(a1), .b0(b0), .b1(b1), .sh0(sh0), .sh1(sh1),
        .gnt0(gnt0), .gnt1(gnt1),
        .alu_sel(alu_sel), .alu_in1(alu_in1), .alu_in2(alu_in2), .alu_sra(alu_sra),
        .alu_out(alu_out), .alu_flags(alu_flags),
        .rvalid(rvalid), .rid(rid), .result(result), .rflags(rflags),
        .err(err), .busy(busy)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] aluResult(input logic [3:0] s, input logic [31:0] x,
                                              input logic [31:0] y, input logic [4:0] sh);
        case (s)
            4'd0:    return x + y;
            4'd1:    return x - y;
            4'd2:    return x * y;
            4'd3:    return (y == 0) ? 32'hFFFFFFFF : x / y;
            4'd4:    return (y == 0) ? x : x % y;
            4'd5:    return x & y;
            4'd6:    return x | y;
            4'd7:    return ~x;
            4'd8:    return x ^ y;
            4'd9:    return x << sh;
            4'd10:   return x >> sh;
            default: return 32'd0;
        endcase
    endfunction

    function automatic logic [5:0] aluFlags(input logic [3:0] s, input logic [31:0] x,
                                            input logic [31:0] y, input logic [4:0] sh);
        logic [31:0] r;
        logic cmp;
        r = aluResult(s, x, y, sh);
        cmp = (s <= 4'd1);
        return {r == 0, r[31], ^r, cmp && (x > y), cmp && (x == y), cmp && (x < y)};
    endfunction

    assign alu_out   = aluResult(alu_sel, alu_in1, alu_in2, alu_sra);
    assign alu_flags = aluFlags(alu_sel, alu_in1, alu_in2, alu_sra);

    function automatic int latencyOf(input logic [3:0] op);
        return (op == 4'd2 || op == 4'd3 || op == 4'd4) ? MD : 1;
    endfunction

    function automatic bit trapOf(input logic [3:0] op, input logic [31:0] b);
`ifdef ALU_ARB_DIV0_TRAP_EN
        return (op == 4'd3 || op == 4'd4) && (b == 0);
`else
        return 1'b0;
`endif
    endfunction

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic modelReset();
        m_left = 0; m_last = 1'b1; m_id = 1'b0; m_trap = 1'b0;
        e_sel = '0; e_in1 = '0; e_in2 = '0; e_sra = '0;
        e_rvalid = 1'b0; e_rid = 1'b0; e_result = '0; e_rflags = '0; e_err = 1'b0;
    endtask

    task automatic setReq(input int id, input logic r, input logic [3:0] op,
                          input logic [31:0] a, input logic [31:0] b, input logic [4:0] sh);
        if (id == 0) begin req0 = r; op0 = op; a0 = a; b0 = b; sh0 = sh; end
        else         begin req1 = r; op1 = op; a1 = a; b1 = b; sh1 = sh; end
    endtask

    task automatic newOp(input int id);
        logic [31:0] b;
        b = ($urandom_range(0, 3) == 0) ? 32'd0 : $urandom;
        setReq(id, (id == 0) ? req0 : req1, 4'($urandom_range(0, 10)), $urandom, b,
               5'($urandom_range(0, 31)));
    endtask

    // One clock: check grants against the model, advance the model across the
    // edge, then compare every registered output
    task automatic applyStimulus();
        bit g0, g1;
        logic [3:0] op;
        logic [31:0] a, b;
        logic [4:0] sh;
        #1;
        g0 = rst_n && (m_left == 0) && req0 && (!req1 || m_last);
        g1 = rst_n && (m_left == 0) && req1 && (!req0 || !m_last);
        obs_win = gnt1 ? 1 : (gnt0 ? 0 : -1);
        checkOutput("gnt0", gnt0, g0);
        checkOutput("gnt1", gnt1, g1);
        @(posedge clk);
        xfer_id = -1;
        if (!rst_n) begin
            modelReset();
        end else if (m_left > 0) begin
            m_left--;
            e_rvalid = (m_left == 0);
            if (m_left == 0) begin
                e_rid    = m_id;
                e_result = m_trap ? 32'd0 : aluResult(e_sel, e_in1, e_in2, e_sra);
                e_rflags = m_trap ? 6'b100000 : aluFlags(e_sel, e_in1, e_in2, e_sra);
                e_err    = m_trap;
            end
        end else begin
            e_rvalid = 1'b0;
            if (g0 || g1) begin
                xfer_id = g1 ? 1 : 0;
                m_last = g1; m_id = g1;
                op = g1 ? op1 : op0; a = g1 ? a1 : a0; b = g1 ? b1 : b0; sh = g1 ? sh1 : sh0;
                m_trap = trapOf(op, b);
                m_left = m_trap ? 1 : latencyOf(op);
                if (!m_trap) begin
                    e_sel = op; e_in1 = a; e_in2 = b; e_sra = sh;
                end
            end
        end
        #1;
        checkOutput("rvalid", rvalid, e_rvalid);
        checkOutput("rid", rid, e_rid);
        checkOutput("result", result, e_result);
        checkOutput("rflags", rflags, e_rflags);
        checkOutput("err", err, e_err);
        checkOutput("busy", busy, m_left > 0);
        checkOutput("alu_sel", alu_sel, e_sel);
        checkOutput("alu_in1", alu_in1, e_in1);
        checkOutput("alu_in2", alu_in2, e_in2);
        checkOutput("alu_sra", alu_sra, e_sra);
    endtask

    // Runs until the result pulse, counting edges and cycles with busy high
    task automatic measureOp(output int edges, output int busy_cycles);
        edges = 0;
        busy_cycles = busy ? 1 : 0;
        for (int i = 0; i < 12; i++) begin
            applyStimulus();
            edges++;
            if (rvalid) break;
            if (busy) busy_cycles++;
        end
    endtask

    initial begin
        int order[$];
        int exp_order[4] = '{0, 1, 0, 1};
        int edges, bc, xfers, pulses;
        bit trap_on;
`ifdef ALU_ARB_DIV0_TRAP_EN
        trap_on = 1'b1;
`else
        trap_on = 1'b0;
`endif
        modelReset();
        xfer_id = -1;
        rst_n = 1'b0;
        setReq(0, 1'b1, 4'd0, 32'd1, 32'd2, 5'd0);
        setReq(1, 1'b0, 4'd0, 32'd0, 32'd0, 5'd0);
        applyStimulus();
        applyStimulus();

        $display("[TB] single add request");
        rst_n = 1'b1;
        setReq(0, 1'b1, 4'd0, 32'd5, 32'd7, 5'd0);
        applyStimulus();
        req0 = 1'b0;
        applyStimulus();
        checkOutput("add_rvalid", rvalid, 1);
        checkOutput("add_result", result, 32'd12);
        checkOutput("add_rid", rid, 0);
        checkOutput("add_rflags", rflags, 6'b000001);
        applyStimulus();

        $display("[TB] tie arbitration after reset");
        rst_n = 1'b0;
        applyStimulus();
        rst_n = 1'b1;
        setReq(0, 1'b1, 4'd0, 32'd1, 32'd2, 5'd0);
        setReq(1, 1'b1, 4'd1, 32'd10, 32'd3, 5'd0);
        for (int i = 0; i < 8; i++) begin
            applyStimulus();
            if (obs_win >= 0) order.push_back(obs_win);
        end
        checkOutput("tie_grant_count", order.size(), 4);
        for (int i = 0; i < order.size() && i < 4; i++)
            checkOutput("tie_grant_order", order[i], exp_order[i]);
        req0 = 1'b0; req1 = 1'b0;
        applyStimulus();

        $display("[TB] multiply latency");
        setReq(1, 1'b1, 4'd2, 32'd3, 32'd4, 5'd0);
        applyStimulus();
        req1 = 1'b0;
        measureOp(edges, bc);
        checkOutput("mul_edges", edges, MD);
        checkOutput("mul_busy_cycles", bc, MD);
        checkOutput("mul_result", result, 32'd12);
        checkOutput("mul_rid", rid, 1);

        $display("[TB] divide by zero");
        setReq(0, 1'b1, 4'd3, 32'd9, 32'd0, 5'd0);
        applyStimulus();
        req0 = 1'b0;
        measureOp(edges, bc);
        checkOutput("div0_edges", edges, trap_on ? 1 : MD);
        checkOutput("div0_err", err, trap_on);
        checkOutput("div0_alu_sel", alu_sel, trap_on ? 4'd2 : 4'd3);

        $display("[TB] reset during multiply");
        setReq(0, 1'b1, 4'd2, 32'd6, 32'd7, 5'd0);
        applyStimulus();
        req0 = 1'b0;
        applyStimulus();
        rst_n = 1'b0;
        applyStimulus();
        checkOutput("rst_rvalid", rvalid, 0);
        checkOutput("rst_busy", busy, 0);
        checkOutput("rst_result", result, 0);
        checkOutput("rst_alu_in1", alu_in1, 0);
        rst_n = 1'b1;
        setReq(0, 1'b1, 4'd0, 32'd1, 32'd1, 5'd0);
        #1;
        checkOutput("post_reset_gnt0", gnt0, 1);
        applyStimulus();
        req0 = 1'b0;
        applyStimulus();

        $display("[TB] held NOT stream");
        setReq(0, 1'b1, 4'd7, 32'd0, 32'd0, 5'd0);
        xfers = 0; pulses = 0;
        for (int i = 0; i < 8; i++) begin
            applyStimulus();
            if (xfer_id == 0) xfers++;
            if (rvalid) begin
                pulses++;
                checkOutput("not_gnt_with_rvalid", gnt0, 1);
                checkOutput("not_result", result, 32'hFFFFFFFF);
                checkOutput("not_rflags", rflags, 6'b010000);
            end
        end
        checkOutput("not_transfers", xfers, 4);
        checkOutput("not_pulses", pulses, 4);
        req0 = 1'b0;
        applyStimulus();

        $display("[TB] random traffic");
        for (int c = 0; c < 400; c++) begin
            rst_n = ($urandom_range(0, 63) != 0);
            if (!req0 || (xfer_id == 0 && $urandom_range(0, 1) == 1)) begin
                req0 = 1'($urandom_range(0, 1));
                newOp(0);
            end
            if (!req1 || (xfer_id == 1 && $urandom_range(0, 1) == 1)) begin
                req1 = 1'($urandom_range(0, 1));
                newOp(1);
            end
            applyStimulus();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/alu_arbiter.md
# alu_arbiter

Shares one combinational 32-bit ALU between two requesters. The block arbitrates round-robin, latches the winner's operands, and drives the ALU's SEL/IN1/IN2/SRA inputs. It holds them for a per-opcode execution time, then captures the result and flags into a registered response tagged with the requester ID. It sits between the instruction-issue logic and the ALU.

## Interface
- MULDIV_CYCLES, 4, execution cycles for opcodes 4'b0010/4'b0011/4'b0100 (mul/div/mod); must be ≥1; all other opcodes take 1 cycle.

- CLK  in  1  clock, rising edge.
- RST_N  in  1  synchronous, active-low reset.
- REQ0, REQ1  in  1  request; held with operands until granted.
- OP0, OP1  in  4  ALU opcode (ALU SEL encoding).
- A0, A1  in  32  first operand.
- B0, B1  in  32  second operand.
- SH0, SH1  in  5  shift/rotate amount.
- GNT0, GNT1  out  1  combinational grant; transfer occurs on a rising edge with REQx && GNTx.
- ALU_SEL  out  4  to ALU SEL.
- ALU_IN1, ALU_IN2  out  32  to ALU IN1/IN2.
- ALU_SRA  out  5  to ALU SRA.
- ALU_OUT  in  32  from ALU OUT.
- ALU_FLAGS  in  6  from ALU as {Z,S,P,G,E,L}, bit 5 = Z.
- RVALID  out  1  one-cycle result pulse.
- RID  out  1  requester index of the result.
- RESULT  out  32  captured ALU_OUT.
- RFLAGS  out  6  captured ALU_FLAGS.
- ERR  out  1  divide-by-zero trap, qualified by RVALID.
- BUSY  out  1  high while state is EXEC.

## Operation
- States: IDLE, EXEC.
- **Arbitration** (IDLE only):
  - Sole requester wins.
  - On a tie, the requester other than LAST wins.
  - LAST resets to 1, so requester 0 wins the first tie.
  - LAST is updated to the winner on every transfer.
  - GNT0 = GNT1 = 0 in EXEC and while RST_N = 0.
- **IDLE → EXEC on transfer:**
  - Latch OPx/Ax/Bx/Shx into the registers driving ALU_*.
  - Latch the winner index.
  - Load CNT = latency − 1, where latency = MULDIV_CYCLES for 0010/0011/0100, else 1.
- **EXEC:**
  - ALU_* stay constant.
  - While CNT ≠ 0, CNT decrements each edge.
  - When CNT = 0, the next edge captures ALU_OUT → RESULT and ALU_FLAGS → RFLAGS, sets RID, pulses RVALID, and returns to IDLE.
- ALU_* registers hold their last values in IDLE; the ALU is never re-driven without a transfer.
- RESULT/RFLAGS/RID/ERR hold their values until the next capture.
- A new REQ arriving during EXEC is ignored until IDLE; there is no queueing.
- **Reset values:**
  - State IDLE, CNT 0, LAST 1.
  - ALU_SEL/ALU_IN1/ALU_IN2/ALU_SRA 0.
  - RVALID 0, RID 0, RESULT 0, RFLAGS 0, ERR 0, BUSY 0.
- **Reset mid-EXEC:** the operation is dropped, no RVALID is produced, and all outputs take their reset values at that edge.

## Timing
- Transfer at edge N.
- Capture at edge N + latency.
- RVALID high for exactly the cycle after that edge.
- Back-to-back:
  - The next transfer can occur in the same cycle RVALID is high.
  - Throughput is one operation per latency + 1 cycles.
- BUSY is high for exactly `latency` cycles per operation.
- GNT is purely combinational from REQ0, REQ1, state, LAST and RST_N; it has no dependence on operands.

## Configuration
- Macro: ALU_ARB_DIV0_TRAP_EN.
- **Defined:**
  - A transfer with OP 0011 or 0100 and B = 0 is trapped.
  - Latency is forced to 1, and ALU_SEL/ALU_IN1/ALU_IN2/ALU_SRA are not updated.
  - Capture yields RESULT = 0, RFLAGS = 6'b100000, ERR = 1.
  - All other operations produce ERR = 0.
- **Undefined:**
  - No trap logic; such operations are issued normally with MULDIV_CYCLES latency.
  - The result is whatever the ALU produces.
  - ERR is tied 0.

## Test plan
- REQ0 alone, OP 0000, A0 = 5, B0 = 7 → GNT0 = 1 that cycle; RVALID one cycle after the transfer edge; RESULT = 12, RID = 0, RFLAGS = 6'b000001.
- After reset, REQ0 and REQ1 both held: grant order 0, 1, 0, 1; each RVALID carries the matching RID; GNT never asserts in EXEC.
- REQ1 OP 0010, A1 = 3, B1 = 4, MULDIV_CYCLES = 4 → BUSY high 4 cycles; RVALID 4 edges after transfer; RESULT = 12, RID = 1.
- REQ0 OP 0011, A0 = 9, B0 = 0:
  - With ALU_ARB_DIV0_TRAP_EN → latency 1, RESULT = 0, RFLAGS = 6'b100000, ERR = 1, ALU_* unchanged.
  - Without → latency 4, ERR = 0.
- RST_N low for one edge during the 2nd cycle of a MUL → no RVALID; all outputs at reset values; the next REQ0 is granted immediately in IDLE.
- REQ0 held continuously with OP 0111 (A0 = 0) → a transfer every 2 cycles; RVALID coincides with GNT0; RESULT = 32'hFFFFFFFF, RFLAGS = 6'b010000.
